// File: rtl/elevator_scan_ctrl_if.sv
// elevator_scan_ctrl_if
// Request channel between the switch/key request decoder and the elevator
// controller.
//   req_valid : single-cycle request strobe (decoder -> controller)
//   req_floor : requested floor index, meaningful while req_valid = 1
//   req_err   : one-cycle registered pulse for an out-of-range floor
//               (controller -> decoder)
// The decoder connects to the master modport and the controller to the slave
// modport.
interface elevator_scan_ctrl_if #(
  parameter int FLOOR_W = 4
);
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_err;

  modport master (
    output req_valid,
    output req_floor,
    input  req_err
  );

  modport slave (
    input  req_valid,
    input  req_floor,
    output req_err
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl
// SCAN-dispatch elevator controller with its own tick prescaler.
// The car holds its direction while requests remain ahead and reverses only
// when none remain. The car moves one floor every TRAVEL_TICKS ticks, and the
// door stays open for DOOR_TICKS ticks at each stop.
//
// Ports:
//   CLOCK_50      : system clock
//   rst           : synchronous active-high reset
//   req_bus       : request channel (slave side: req_valid, req_floor, req_err)
//   pending       : outstanding requests, bit i = floor i (drives LEDR)
//   cur_floor     : one-hot car position
//   cur_floor_idx : binary car position
//   state         : 01 IDLE, 10 BUSY, 11 TRAVELLING
//   direction     : 1 = UP, 0 = DOWN
//   door_open     : high while in BUSY
//   tick          : one-cycle prescaler pulse
//   door_hold     : only when ELEVATOR_DOOR_HOLD_EN is defined. It freezes the
//                   door counter while the door is open.
//
// Optional feature macro: ELEVATOR_DOOR_HOLD_EN.
// TICK_DIV must be at least 2.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_W      = 4,
  parameter int TICK_DIV     = 50_000_000,
  parameter int TRAVEL_TICKS = 1,
  parameter int DOOR_TICKS   = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  elevator_scan_ctrl_if.slave   req_bus,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [NUM_FLOORS-1:0] cur_floor,
  output logic [FLOOR_W-1:0]    cur_floor_idx,
  output logic [1:0]            state,
  output logic                  direction,
  output logic                  door_open,
  output logic                  tick
);

  localparam int PW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
  localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1)   ? $clog2(DOOR_TICKS)   : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_BUSY   = 2'b10,
    ST_TRAVEL = 2'b11
  } state_t;

  state_t          fsm;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   travel_cnt;
  logic [DW-1:0]   door_cnt;

  logic                  hold_active;
  logic                  req_in_range;
  logic                  door_restart;
  logic [NUM_FLOORS-1:0] req_mask;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] svc_clr;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] next_onehot;
  logic [FLOOR_W-1:0]    next_idx;
  logic                  req_above;
  logic                  req_below;
  logic                  req_ahead;
  logic                  req_behind;
  logic                  idle_hit;
  logic                  arrive_hit;
  logic                  travel_done;
  logic                  door_done;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold_active = door_hold;
`else
  assign hold_active = 1'b0;
`endif

  assign state = fsm;

  // A request for the floor where the door is already open is never latched.
  // Instead it keeps the door open longer.
  assign req_in_range = req_bus.req_valid && (int'(req_bus.req_floor) < NUM_FLOORS);
  assign door_restart = req_in_range && (fsm == ST_BUSY) && (req_bus.req_floor == cur_floor_idx);
  assign set_mask     = door_restart ? '0 : req_mask;

  always_comb begin
    above_mask = '0;
    below_mask = '0;
    req_mask   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (FLOOR_W'(i) > cur_floor_idx);
      below_mask[i] = (FLOOR_W'(i) < cur_floor_idx);
      req_mask[i]   = req_in_range && (req_bus.req_floor == FLOOR_W'(i));
    end
  end

  assign req_above  = |(pending & above_mask);
  assign req_below  = |(pending & below_mask);
  assign req_ahead  = direction ? req_above : req_below;
  assign req_behind = direction ? req_below : req_above;
  assign idle_hit   = |(pending & cur_floor);

  assign next_idx    = direction ? cur_floor_idx + FLOOR_W'(1) : cur_floor_idx - FLOOR_W'(1);
  assign next_onehot = direction ? (cur_floor << 1) : (cur_floor >> 1);
  // A request arriving on the arrival edge for the arrival floor also counts
  // as a stop. It is absorbed, so its bit never becomes visible.
  assign arrive_hit  = |((pending | set_mask) & next_onehot);

  assign travel_done = tick && (travel_cnt == TW'(TRAVEL_TICKS - 1));
  assign door_done   = tick && !hold_active && (door_cnt == DW'(DOOR_TICKS - 1));

  always_comb begin
    svc_clr = '0;
    case (fsm)
      ST_IDLE:   if (idle_hit) svc_clr = cur_floor;
      ST_TRAVEL: if (travel_done && arrive_hit) svc_clr = next_onehot;
      default:   svc_clr = '0;
    endcase
  end

  // The tick register is loaded one cycle early. It is therefore high exactly
  // in the cycle where the prescaler holds TICK_DIV-1.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
      tick  <= (presc == PW'(TICK_DIV - 2));
    end
  end

  // Request register and error pulse. A new request and a service clear can
  // land on the same edge, and both take effect.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pending         <= '0;
      req_bus.req_err <= 1'b0;
    end else begin
      pending         <= (pending | set_mask) & ~svc_clr;
      req_bus.req_err <= req_bus.req_valid && !req_in_range;
    end
  end

  // SCAN dispatch FSM: car position, direction, door and both counters.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      fsm           <= ST_IDLE;
      cur_floor     <= NUM_FLOORS'(1);
      cur_floor_idx <= '0;
      direction     <= 1'b1;
      door_open     <= 1'b0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (idle_hit) begin
            fsm       <= ST_BUSY;
            door_open <= 1'b1;
            door_cnt  <= '0;
          end else if (|pending) begin
            // When requests exist on both sides, keep the current direction.
            if (!(req_above && req_below)) direction <= req_above;
            fsm        <= ST_TRAVEL;
            travel_cnt <= '0;
          end
        end
        ST_TRAVEL: begin
          if (travel_done) begin
            travel_cnt    <= '0;
            cur_floor     <= next_onehot;
            cur_floor_idx <= next_idx;
            if (arrive_hit) begin
              fsm       <= ST_BUSY;
              door_open <= 1'b1;
              door_cnt  <= '0;
            end
          end else if (tick) begin
            travel_cnt <= travel_cnt + TW'(1);
          end
        end
        ST_BUSY: begin
          if (door_restart) begin
            door_cnt <= '0;
          end else if (door_done) begin
            door_cnt <= '0;
            if (req_ahead) begin
              fsm        <= ST_TRAVEL;
              door_open  <= 1'b0;
              travel_cnt <= '0;
            end else if (req_behind) begin
              direction  <= ~direction;
              fsm        <= ST_TRAVEL;
              door_open  <= 1'b0;
              travel_cnt <= '0;
            end else begin
              fsm       <= ST_IDLE;
              door_open <= 1'b0;
            end
          end else if (tick && !hold_active) begin
            door_cnt <= door_cnt + DW'(1);
          end
        end
        default: begin
          fsm       <= ST_IDLE;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule
